// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   - op encodings presented by the EX stage
//   - sequencer state enum
//   - default iteration count and counter width
//   - conditional two's-complement negation, used both for operand magnitudes
//     and for the final sign fixup
package muldiv_pkg;

    localparam int unsigned ITER_DEF  = 32;
    localparam int unsigned CNT_W_DEF = 6;

    // Widest value cond_negate handles; covers a 2*WIDTH product for WIDTH <= 32.
    localparam int unsigned MAX_W = 64;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        StIdle,
        StPrep,
        StCalc,
        StFix
    } state_e;

    // Returns -v when neg is set, v otherwise (modulo 2^MAX_W). Callers
    // zero-extend into MAX_W and truncate back, which keeps the low bits exact.
    // With neg = sign bit this yields the two's-complement magnitude.
    function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] v,
                                                     input logic             neg);
        return neg ? (~v + MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: EX-stage <-> HI/LO sequencer connection.
//   master (EX / pipeline side): drives start, op, rs_val, rt_val, rd_hilo;
//                                observes busy, stall_req, done, hi, lo.
//   slave  (sequencer side):     the mirror image.
interface muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             rd_hilo;
    logic             busy;
    logic             stall_req;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, rd_hilo,
        input  busy, stall_req, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, rd_hilo,
        output busy, stall_req, done, hi, lo
    );

endinterface

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: datapath registers plus one iteration step of an unsigned
// shift-add multiplier and an unsigned restoring divider.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   mode         0 = multiply, 1 = divide
//   load         load op_a/op_b and clear the partial remainder
//   step         perform one iteration
//   op_a, op_b   multiplicand/dividend, multiplier/divisor (unsigned magnitudes)
//   product      full 2*WIDTH product (valid after WIDTH steps in multiply mode)
//   quotient     quotient (valid after WIDTH steps in divide mode)
//   remainder    remainder (valid after WIDTH steps in divide mode)
module muldiv_iter_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder
);

    // Multiply: acc holds {partial upper, remaining multiplier bits}.
    // Divide:   acc[WIDTH-1:0] holds remaining dividend bits shifting out of
    //           the top while quotient bits shift in at the bottom.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   opb_q, opb_d;

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        acc_d = acc_q;
        rem_d = rem_q;
        opb_d = opb_q;

        add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        shifted = {rem_q, acc_q[WIDTH-1]};
        trial   = shifted - {1'b0, opb_q};

        if (load) begin
            acc_d = {{WIDTH{1'b0}}, op_a};
            rem_d = '0;
            opb_d = op_b;
        end else if (step) begin
            if (!mode) begin
                // Carry out of the add becomes the new MSB after the right shift.
                acc_d = {add_sum, acc_q[WIDTH-1:1]};
            end else if (shifted >= {1'b0, opb_q}) begin
                // Accepted subtraction: remainder stays below the divisor, so it
                // fits WIDTH bits (divisor 0 accepts every step and rebuilds the
                // dividend, which also fits).
                rem_d              = trial[WIDTH-1:0];
                acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d              = shifted[WIDTH-1:0];
                acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            rem_q <= '0;
            opb_q <= '0;
        end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            opb_q <= opb_d;
        end
    end

    assign product   = acc_q;
    assign quotient  = acc_q[WIDTH-1:0];
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle controller for the shared HI/LO multiply/divide
// resource. IDLE accepts an op; PREP forms operand magnitudes and result signs;
// CALC runs ITER iterations on muldiv_iter_core; FIX applies the sign and
// writes HI/LO, pulsing done in the following cycle.
// Ports:
//   clk    system clock (rising edge)
//   reset  synchronous active-high reset; abandons any op and clears HI/LO
//   bus    slave side of muldiv_sequencer_if:
//            start/op/rs_val/rt_val/rd_hilo in; busy/stall_req/done/hi/lo out
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = WIDTH,
    // 2**CNT_W must exceed ITER.
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input logic                clk,
    input logic                reset,
    muldiv_sequencer_if.slave  bus
);

    localparam int unsigned PW = 2 * WIDTH;

    state_e           state_q;
    logic             is_div_q;
    logic             is_signed_q;
    logic [WIDTH-1:0] rs_q;
    logic [WIDTH-1:0] rt_q;
    logic             neg_res_q;   // sign of product / quotient
    logic             neg_rem_q;   // sign of remainder (dividend sign)
    logic             div0_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [PW-1:0]    product;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [PW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign rs_neg = is_signed_q & rs_q[WIDTH-1];
    assign rt_neg = is_signed_q & rt_q[WIDTH-1];
    assign mag_a  = WIDTH'(cond_negate(MAX_W'(rs_q), rs_neg));
    assign mag_b  = WIDTH'(cond_negate(MAX_W'(rt_q), rt_neg));

    assign prod_fix = PW'(cond_negate(MAX_W'(product), neg_res_q));
    assign quo_fix  = WIDTH'(cond_negate(MAX_W'(quotient), neg_res_q));
    assign rem_fix  = WIDTH'(cond_negate(MAX_W'(remainder), neg_rem_q));

    muldiv_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .mode      (is_div_q),
        .load      (state_q == StPrep),
        .step      (state_q == StCalc),
        .op_a      (mag_a),
        .op_b      (mag_b),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            div0_q      <= 1'b0;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                is_div_q    <= (bus.op == OP_DIV) || (bus.op == OP_DIVU);
                                is_signed_q <= (bus.op == OP_MULT) || (bus.op == OP_DIV);
                                rs_q        <= bus.rs_val;
                                rt_q        <= bus.rt_val;
                                busy_q      <= 1'b1;
                                state_q     <= StPrep;
                            end
                            OP_MTHI: hi_q <= bus.rs_val;
                            OP_MTLO: lo_q <= bus.rs_val;
                            default: ;  // NOP and reserved encoding
                        endcase
                    end
                end
                StPrep: begin
                    neg_res_q <= rs_neg ^ rt_neg;
                    neg_rem_q <= rs_neg;
                    div0_q    <= is_div_q && (rt_q == '0);
                    cnt_q     <= '0;
                    state_q   <= StCalc;
                end
                StCalc: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    if (!is_div_q) begin
                        hi_q <= prod_fix[PW-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end else if (div0_q) begin
                        // Divide by zero: raw dividend and all-ones, no sign fixup.
                        hi_q <= rs_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    // Only a busy sequencer stalls; an idle one serves MFHI/MFLO directly.
    assign bus.stall_req = busy_q & (bus.start | bus.rd_hilo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed test-plan cases followed by
// randomized arithmetic ops, checked against a plain-arithmetic HI/LO model.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int unsigned W   = 32;
    localparam int          LAT = W + 2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: what HI/LO must hold after the op, from plain integer arithmetic.
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        logic [63:0]     t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        case (op)
            OP_MULT: begin
                sp = sa * sb; t = 64'(sp);
                m_hi = t[63:32]; m_lo = t[31:0];
            end
            OP_MULTU: begin
                up = ua * ub; t = up;
                m_hi = t[63:32]; m_lo = t[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (b == '0) begin
                    m_hi = a; m_lo = '1;
                end else if (op == OP_DIV) begin
                    sq = sa / sb; sr = sa % sb;
                    t = 64'(sq); m_lo = t[31:0];
                    t = 64'(sr); m_hi = t[31:0];
                end else begin
                    t = ua / ub; m_lo = t[31:0];
                    t = ua % ub; m_hi = t[31:0];
                end
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    // Arithmetic op launched at edge E0; checks every cycle up to E0+LAT+1.
    // rd: hold rd_hilo high across the whole op (including the launch cycle).
    // second_at: k index at which a second start (second_op) is presented, -1 for none.
    task automatic arith_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input bit rd, input int second_at,
                            input logic [2:0] second_op);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_val  = a;
        bus.rt_val  = b;
        bus.rd_hilo = rd;
        #1;
        check({tag, " idle_stall"}, 64'(bus.stall_req), 64'(0));
        @(negedge clk);
        bus.start = 1'b0;
        model(op, a, b);
        for (int k = 0; k < LAT; k++) begin
            if (k == second_at) begin
                bus.start  = 1'b1;
                bus.op     = second_op;
                bus.rs_val = $urandom;
                bus.rt_val = $urandom;
            end
            #1;
            check({tag, " busy"}, 64'(bus.busy), 64'(1));
            check({tag, " done_early"}, 64'(bus.done), 64'(0));
            check({tag, " stall"}, 64'(bus.stall_req), 64'(rd || (k == second_at)));
            @(negedge clk);
            bus.start = 1'b0;
        end
        #1;
        check({tag, " busy_end"}, 64'(bus.busy), 64'(0));
        check({tag, " done"}, 64'(bus.done), 64'(1));
        check({tag, " stall_end"}, 64'(bus.stall_req), 64'(0));
        check({tag, " hi"}, 64'(bus.hi), 64'(m_hi));
        check({tag, " lo"}, 64'(bus.lo), 64'(m_lo));
        @(negedge clk);
        bus.rd_hilo = 1'b0;
        #1;
        check({tag, " done_once"}, 64'(bus.done), 64'(0));
        check({tag, " hi_hold"}, 64'(bus.hi), 64'(m_hi));
    endtask

    // Single-cycle op in IDLE (MTHI/MTLO/NOP/reserved).
    task automatic idle_op(input string tag, input logic [2:0] op, input logic [W-1:0] a);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = $urandom;
        @(negedge clk);
        bus.start = 1'b0;
        model(op, a, '0);
        #1;
        check({tag, " busy"}, 64'(bus.busy), 64'(0));
        check({tag, " done"}, 64'(bus.done), 64'(0));
        check({tag, " hi"}, 64'(bus.hi), 64'(m_hi));
        check({tag, " lo"}, 64'(bus.lo), 64'(m_lo));
    endtask

    initial begin
        logic [2:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           seen_done;

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = OP_NOP;
        bus.rs_val  = '0;
        bus.rt_val  = '0;
        bus.rd_hilo = 1'b0;
        m_hi = '0;
        m_lo = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset hi", 64'(bus.hi), 64'(0));
        check("reset lo", 64'(bus.lo), 64'(0));
        check("reset busy", 64'(bus.busy), 64'(0));
        check("reset done", 64'(bus.done), 64'(0));
        check("reset stall", 64'(bus.stall_req), 64'(0));

        arith_op("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, -1, OP_NOP);
        arith_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, OP_NOP);
        arith_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0, -1, OP_NOP);
        arith_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, -1, OP_NOP);
        arith_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, OP_NOP);
        arith_op("div_by0", OP_DIV, 32'h0000_1234, 32'd0, 1'b0, -1, OP_NOP);
        arith_op("div_neg_by0", OP_DIV, 32'hFFFF_0000, 32'd0, 1'b0, -1, OP_NOP);
        // rd_hilo held through the op, second start presented for edge E5.
        arith_op("mult_rd_2nd", OP_MULT, 32'h0001_2345, 32'hFFFF_FF00, 1'b1, 4, OP_MULTU);
        arith_op("divu_mtlo_busy", OP_DIVU, 32'hDEAD_BEEF, 32'd3, 1'b0, 10, OP_MTLO);

        idle_op("mtlo", OP_MTLO, 32'h0000_ABCD);
        idle_op("mthi", OP_MTHI, 32'h1357_9BDF);
        idle_op("nop", OP_NOP, 32'hFFFF_FFFF);
        idle_op("reserved", 3'b111, 32'h5555_AAAA);

        // Reset in the middle of a DIV: abandoned, HI/LO cleared, no done.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = OP_DIV;
        bus.rs_val = 32'h7654_3210;
        bus.rt_val = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset       = 1'b1;
        bus.rd_hilo = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        #1;
        check("rst_mid busy", 64'(bus.busy), 64'(0));
        check("rst_mid done", 64'(bus.done), 64'(0));
        check("rst_mid hi", 64'(bus.hi), 64'(0));
        check("rst_mid lo", 64'(bus.lo), 64'(0));
        check("rst_mid stall", 64'(bus.stall_req), 64'(0));
        bus.rd_hilo = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen_done = 1'b1;
        end
        check("rst_mid no_done", 64'(seen_done), 64'(0));

        for (int i = 0; i < 14; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
            arith_op($sformatf("rand%0d", i), rop, ra, rb, bit'($urandom_range(0, 1)), -1,
                     OP_NOP);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
